bootrom_axil_slave: RTL and testbench
=====================================

# bootrom_axil_slave

AXI4-Lite slave front-end for the 1024x64 boot ROM bank: accepts 64-bit read requests from the SoC interconnect, drives the ROM's request/address port, captures the ROM word after a configurable latency and returns it on the R channel. All writes to the read-only region are absorbed and answered with SLVERR. It sits directly upstream of the boot ROM, between the peripheral crossbar and the `bootrom` instance.

## Interface
- `ROM_LATENCY`, default 0: cycles from the `rom_req_o` cycle to valid `rom_rdata_i`. 0 means a combinational distributed ROM. Legal range 0..3.
- `ROM_WORDS`, default 1024: ROM depth in 64-bit words. Byte offsets at or above `ROM_WORDS*8` are out of range.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `ar_valid_i` in 1, `ar_ready_o` out 1, `ar_addr_i` in 64: read address channel. The address is the byte offset within the ROM window.
- `r_valid_o` out 1, `r_ready_i` in 1, `r_data_o` out 64, `r_resp_o` out 2: read data channel.
- `aw_valid_i` in 1, `aw_ready_o` out 1, `aw_addr_i` in 64: write address channel. The address is ignored.
- `w_valid_i` in 1, `w_ready_o` out 1, `w_data_i` in 64, `w_strb_i` in 8: write data channel. Data and strobe are ignored.
- `b_valid_o` out 1, `b_ready_i` in 1, `b_resp_o` out 2: write response channel.
- `rom_req_o` out 1: one-cycle ROM read strobe.
- `rom_addr_o` out 64: registered, 8-byte-aligned ROM address (bits [2:0] = 0).
- `rom_rdata_i` in 64: ROM read data.

## Operation
- **Read FSM** has four states.
  - `R_IDLE`: `ar_ready_o`=1. On AR handshake, latch `{ar_addr_i[63:3],3'b0}` into `rom_addr_o`, set the range flag, go to `R_ISSUE`.
  - `R_ISSUE`: `rom_req_o`=1 only if in range. If `ROM_LATENCY`=0, capture `rom_rdata_i` into `r_data_o` and go to `R_RESP`. Otherwise load the counter with `ROM_LATENCY-1` and go to `R_WAIT`.
  - `R_WAIT`: decrement the counter. When the counter is 0, capture `rom_rdata_i` and go to `R_RESP`.
  - `R_RESP`: `r_valid_o`=1. `r_data_o` and `r_resp_o` are held stable until `r_ready_i`. On handshake, go to `R_IDLE`.
- `ar_ready_o` is 0 in every state except `R_IDLE`. At most one read is outstanding.
- In range: `r_resp_o`=2'b00 (OKAY).
- Out of range: no `rom_req_o`, `r_data_o`=0, `r_resp_o`=2'b10 (SLVERR). Latency is identical to an in-range read.
- Unaligned address: bits [2:0] are ignored, the full aligned word is returned, response is OKAY.
- `rom_addr_o` changes only on an AR handshake and is otherwise held.
- **Write path** runs independently of the read FSM.
  - `aw_ready_o` is 1 until AW is accepted. `w_ready_o` is 1 until W is accepted.
  - AW and W may arrive in either order or in the same cycle.
  - Once both have been accepted, assert `b_valid_o` with `b_resp_o`=2'b10 in the next cycle. Both readies are held at 0 while `b_valid_o`=1.
  - On B handshake, clear the accepted flags. Both readies return to 1 in the next cycle.
- Read and write transactions may be in flight simultaneously with no interaction. A write never reaches the ROM.

## Timing
- Reset values: `ar_ready_o`=1, `aw_ready_o`=1, `w_ready_o`=1, `r_valid_o`=0, `b_valid_o`=0, `rom_req_o`=0, `rom_addr_o`=0, `r_data_o`=0, `r_resp_o`=0, `b_resp_o`=0. Read FSM is in `R_IDLE`.
- Read latency, AR handshake edge to `r_valid_o` high, is `ROM_LATENCY`+2 cycles. Example with L=0: handshake in cycle N, `rom_req_o` in N+1, `r_valid_o` in N+2.
- Read throughput with `r_ready_i` tied high: one read per `ROM_LATENCY`+3 cycles.
- Write response: `b_valid_o` rises 1 cycle after the later of the AW and W handshakes.
- All outputs are registered or decoded from FSM state only. There are no combinational paths from `*_valid_i` or `*_ready_i` to outputs.
- Reset mid-transaction: any in-flight read or write is dropped, no response is issued, and all outputs return to their reset values asynchronously.

## Test plan
- Back-to-back reads at offsets 0x0, 0x8, 0x1FF8, with the ROM model preloaded to word index × 0x0101010101010101 -> `r_data_o` matches, `r_resp_o`=0, `rom_addr_o` = 0x0, 0x8, 0x1FF8, latency `ROM_LATENCY`+2, checked for L=0 and L=2.
- Read at offset 0x2000 -> `rom_req_o` never asserts, `r_data_o`=0, `r_resp_o`=2'b10.
- Read at unaligned offset 0x13 -> `rom_addr_o`=0x10, word 2 returned, OKAY.
- `r_ready_i` held low for 5 cycles -> `r_valid_o`, `r_data_o` and `r_resp_o` stable, `ar_ready_o`=0 throughout, and a new AR is accepted only after the R handshake.
- Write with W arriving 3 cycles before AW, then with AW and W in the same cycle, plus `b_ready_i` delayed 4 cycles -> one B per write, `b_resp_o`=2'b10, no `rom_req_o`; a concurrent read completes unaffected.
- `rst_ni` pulsed low while in `R_WAIT` with `b_valid_o`=1 -> all outputs take reset values immediately, and a subsequent read completes normally.

Source files
------------

// File: rtl/bootrom_axil_slave.sv
// bootrom_axil_slave: AXI4-Lite read front-end for the boot ROM; writes are absorbed with SLVERR.
module bootrom_axil_slave #(
  parameter int ROM_LATENCY = 0,
  parameter int ROM_WORDS   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ar_valid_i,
  output logic        ar_ready_o,
  input  logic [63:0] ar_addr_i,
  output logic        r_valid_o,
  input  logic        r_ready_i,
  output logic [63:0] r_data_o,
  output logic [1:0]  r_resp_o,
  input  logic        aw_valid_i,
  output logic        aw_ready_o,
  input  logic [63:0] aw_addr_i,
  input  logic        w_valid_i,
  output logic        w_ready_o,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_strb_i,
  output logic        b_valid_o,
  input  logic        b_ready_i,
  output logic [1:0]  b_resp_o,
  output logic        rom_req_o,
  output logic [63:0] rom_addr_o,
  input  logic [63:0] rom_rdata_i
);
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;
  localparam logic [1:0]  LAT_M1    = (ROM_LATENCY > 0) ? 2'(ROM_LATENCY - 1) : 2'd0;
  localparam logic [63:0] ROM_BYTES = 64'(ROM_WORDS) * 64'd8;
  r_state_e    state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        in_range_q, in_range_d;
  logic [63:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        b_valid_q, b_valid_d;
  logic [1:0]  b_resp_q, b_resp_d;
  logic        capture, b_hs;
  logic        unused_ok;
  assign unused_ok = ^{aw_addr_i, w_data_i, w_strb_i};
  // the ROM word is valid in ISSUE for a combinational ROM, else on the last WAIT cycle
  assign capture = (state_q == R_ISSUE && ROM_LATENCY == 0) || (state_q == R_WAIT && cnt_q == 2'd0);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    in_range_d = in_range_q;
    r_data_d   = capture ? (in_range_q ? rom_rdata_i : 64'd0) : r_data_q;
    r_resp_d   = capture ? (in_range_q ? 2'b00 : 2'b10) : r_resp_q;
    case (state_q)
      R_IDLE: if (ar_valid_i) begin
        state_d    = R_ISSUE;
        addr_d     = {ar_addr_i[63:3], 3'b000};
        in_range_d = ar_addr_i < ROM_BYTES;
      end
      R_ISSUE: begin
        state_d = (ROM_LATENCY == 0) ? R_RESP : R_WAIT;
        cnt_d   = LAT_M1;
      end
      R_WAIT: begin
        cnt_d   = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd0) ? R_RESP : R_WAIT;
      end
      default: state_d = r_ready_i ? R_IDLE : R_RESP;
    endcase
  end
  assign b_hs      = b_valid_q & b_ready_i;
  assign aw_done_d = ~b_hs & (aw_done_q | aw_valid_i);
  assign w_done_d  = ~b_hs & (w_done_q | w_valid_i);
  assign b_valid_d = ~b_hs & (b_valid_q | (aw_done_d & w_done_d));
  assign b_resp_d  = b_valid_d ? 2'b10 : b_resp_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= R_IDLE;
      cnt_q      <= 2'd0;
      addr_q     <= 64'd0;
      in_range_q <= 1'b0;
      r_data_q   <= 64'd0;
      r_resp_q   <= 2'b00;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      in_range_q <= in_range_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
    end
  end
  assign ar_ready_o = state_q == R_IDLE;
  assign r_valid_o  = state_q == R_RESP;
  assign rom_req_o  = state_q == R_ISSUE && in_range_q;
  assign rom_addr_o = addr_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign aw_ready_o = ~aw_done_q;
  assign w_ready_o  = ~w_done_q;
  assign b_valid_o  = b_valid_q;
  assign b_resp_o   = b_resp_q;
endmodule

// File: tb/tb_bootrom_axil_slave.sv
// tb_bootrom_axil_slave: two instances (ROM latency 0 and 2) checked every cycle against a
// transaction-timeline model, plus directed reads/writes with literal expectations.
module tb_bootrom_axil_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        ar_valid [2], ar_ready [2], r_valid [2], r_ready [2];
  logic        aw_valid [2], aw_ready [2], w_valid [2], w_ready [2];
  logic        b_valid [2], b_ready [2], rom_req [2];
  logic [63:0] ar_addr [2], aw_addr [2], w_data [2], r_data [2], rom_addr [2], rom_rdata [2];
  logic [7:0]  w_strb [2];
  logic [1:0]  r_resp [2], b_resp [2];
  int checks = 0;
  int failures = 0;
  int reqs [2];

  function automatic logic [63:0] rom_word(input logic [63:0] a);
    logic [63:0] idx;
    idx = a >> 3;
    return (idx < 64'd1024) ? idx * 64'h0101010101010101 : 64'hDEADBEEFDEADBEEF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    bootrom_axil_slave #(.ROM_LATENCY(2 * g), .ROM_WORDS(1024)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .ar_valid_i(ar_valid[g]), .ar_ready_o(ar_ready[g]), .ar_addr_i(ar_addr[g]),
      .r_valid_o(r_valid[g]), .r_ready_i(r_ready[g]), .r_data_o(r_data[g]), .r_resp_o(r_resp[g]),
      .aw_valid_i(aw_valid[g]), .aw_ready_o(aw_ready[g]), .aw_addr_i(aw_addr[g]),
      .w_valid_i(w_valid[g]), .w_ready_o(w_ready[g]), .w_data_i(w_data[g]), .w_strb_i(w_strb[g]),
      .b_valid_o(b_valid[g]), .b_ready_i(b_ready[g]), .b_resp_o(b_resp[g]),
      .rom_req_o(rom_req[g]), .rom_addr_o(rom_addr[g]), .rom_rdata_i(rom_rdata[g]));
    if (g == 0) begin : comb_rom
      assign rom_rdata[g] = rom_word(rom_addr[g]);
    end else begin : pipe_rom
      logic [63:0] p1, p2;
      always @(posedge clk) begin
        p1 <= rom_word(rom_addr[g]);
        p2 <= p1;
      end
      assign rom_rdata[g] = p2;
    end
  end

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[k=%0d] @%0t got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  // model: timeline of the current read (age = cycles since AR handshake) and write flags
  bit          m_busy [2], m_in [2], m_awg [2], m_wg [2], m_bv [2], m_wrote [2];
  int          m_age [2];
  logic [63:0] m_addr [2], m_new_d [2], m_old_d [2];
  logic [1:0]  m_new_r [2], m_old_r [2];
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0; m_age[k] <= 0; m_addr[k] <= '0; m_in[k] <= 1'b0;
        m_new_d[k] <= '0; m_old_d[k] <= '0; m_new_r[k] <= '0; m_old_r[k] <= '0;
        m_awg[k] <= 1'b0; m_wg[k] <= 1'b0; m_bv[k] <= 1'b0; m_wrote[k] <= 1'b0;
      end else begin
        if (!m_busy[k]) begin
          if (ar_valid[k]) begin
            m_busy[k]  <= 1'b1;
            m_age[k]   <= 1;
            m_addr[k]  <= ar_addr[k] & ~64'h7;
            m_in[k]    <= ar_addr[k] < 64'h2000;
            m_new_d[k] <= (ar_addr[k] < 64'h2000) ? rom_word(ar_addr[k]) : 64'd0;
            m_new_r[k] <= (ar_addr[k] < 64'h2000) ? 2'b00 : 2'b10;
          end
        end else if (m_age[k] >= 2 * k + 2 && r_ready[k]) begin
          m_busy[k]  <= 1'b0;
          m_old_d[k] <= m_new_d[k];
          m_old_r[k] <= m_new_r[k];
        end else m_age[k] <= m_age[k] + 1;
        if (m_bv[k] && b_ready[k]) begin
          m_awg[k] <= 1'b0; m_wg[k] <= 1'b0; m_bv[k] <= 1'b0;
        end else begin
          if (aw_valid[k]) m_awg[k] <= 1'b1;
          if (w_valid[k]) m_wg[k] <= 1'b1;
          if ((m_awg[k] || aw_valid[k]) && (m_wg[k] || w_valid[k])) begin
            m_bv[k] <= 1'b1; m_wrote[k] <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (rom_req[k]) reqs[k]++;
        chk("ar_ready", k, 64'(ar_ready[k]), 64'(!m_busy[k]));
        chk("rom_req", k, 64'(rom_req[k]), 64'(m_busy[k] && m_age[k] == 1 && m_in[k]));
        chk("rom_addr", k, rom_addr[k], m_addr[k]);
        chk("r_valid", k, 64'(r_valid[k]), 64'(m_busy[k] && m_age[k] >= 2 * k + 2));
        chk("r_data", k, r_data[k], (m_busy[k] && m_age[k] >= 2 * k + 2) ? m_new_d[k] : m_old_d[k]);
        chk("r_resp", k, 64'(r_resp[k]), 64'((m_busy[k] && m_age[k] >= 2 * k + 2) ? m_new_r[k] : m_old_r[k]));
        chk("aw_ready", k, 64'(aw_ready[k]), 64'(!m_awg[k]));
        chk("w_ready", k, 64'(w_ready[k]), 64'(!m_wg[k]));
        chk("b_valid", k, 64'(b_valid[k]), 64'(m_bv[k]));
        chk("b_resp", k, 64'(b_resp[k]), m_wrote[k] ? 64'd2 : 64'd0);
      end
    end
  end

  task automatic ar_hs(input int k, input logic [63:0] a);
    bit ok = 0;
    ar_valid[k] = 1'b1; ar_addr[k] = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = ar_ready[k];
    end
    chk("ar_hs_timeout", k, 64'(ok), 64'd1);
    @(posedge clk); #1;
    ar_valid[k] = 1'b0;
  endtask

  task automatic aw_hs(input int k);
    bit ok = 0;
    aw_valid[k] = 1'b1; aw_addr[k] = 64'h40;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = aw_ready[k];
    end
    chk("aw_hs_timeout", k, 64'(ok), 64'd1);
    @(posedge clk); #1;
    aw_valid[k] = 1'b0;
  endtask

  task automatic w_hs(input int k);
    bit ok = 0;
    w_valid[k] = 1'b1; w_data[k] = 64'hFFFF_0000_FFFF_0000; w_strb[k] = 8'hFF;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = w_ready[k];
    end
    chk("w_hs_timeout", k, 64'(ok), 64'd1);
    @(posedge clk); #1;
    w_valid[k] = 1'b0;
  endtask

  task automatic wait_b(input int k);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = b_valid[k];
    end
    chk("b_timeout", k, 64'(ok), 64'd1);
    chk("b_resp_lit", k, 64'(b_resp[k]), 64'd2);
  endtask

  task automatic wr(input int k, input int wlead, input int bdelay);
    fork
      begin repeat (wlead) @(posedge clk); #1; aw_hs(k); end
      w_hs(k);
    join
    wait_b(k);
    repeat (bdelay) @(negedge clk);
    chk("b_hold_lit", k, 64'(b_valid[k]), 64'd1);
    b_ready[k] = 1'b1;
    @(posedge clk); #1;
    b_ready[k] = 1'b0;
  endtask

  task automatic rd(input int k, input logic [63:0] a, input logic [63:0] ea, input logic [63:0] ed,
                    input logic [1:0] er, input int hold, input bit pre, input logic [63:0] na);
    int lat = 1;
    bit ok = 0;
    ar_hs(k, a);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = r_valid[k];
      if (!ok) begin @(posedge clk); lat++; end
    end
    chk("r_timeout", k, 64'(ok), 64'd1);
    chk("rd_latency", k, 64'(lat), (k == 0) ? 64'd2 : 64'd4);
    chk("rom_addr_lit", k, rom_addr[k], ea);
    chk("r_data_lit", k, r_data[k], ed);
    chk("r_resp_lit", k, 64'(r_resp[k]), 64'(er));
    if (pre) begin ar_valid[k] = 1'b1; ar_addr[k] = na; end
    repeat (hold) @(negedge clk);
    chk("r_data_held", k, r_data[k], ed);
    chk("ar_ready_busy", k, 64'(ar_ready[k]), 64'd0);
    r_ready[k] = 1'b1;
    @(posedge clk); #1;
    r_ready[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    for (int k = 0; k < 2; k++) begin
      ar_valid[k] = 0; ar_addr[k] = 0; r_ready[k] = 0; aw_valid[k] = 0; aw_addr[k] = 0;
      w_valid[k] = 0; w_data[k] = 0; w_strb[k] = 0; b_ready[k] = 0; reqs[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ar_ready", k, 64'(ar_ready[k]), 64'd1);
      chk("rst_aw_ready", k, 64'(aw_ready[k]), 64'd1);
      chk("rst_r_valid", k, 64'(r_valid[k]), 64'd0);
      chk("rst_b_valid", k, 64'(b_valid[k]), 64'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      r0 = reqs[k];
      rd(k, 64'h0, 64'h0, 64'h0, 2'b00, 0, 1'b1, 64'h8);
      rd(k, 64'h8, 64'h8, 64'h0101010101010101, 2'b00, 0, 1'b1, 64'h1FF8);
      rd(k, 64'h1FF8, 64'h1FF8, 64'h03030303030302FF, 2'b00, 0, 1'b0, 64'h0);
      chk("req_count_inrange", k, 64'(reqs[k] - r0), 64'd3);
      r0 = reqs[k];
      rd(k, 64'h2000, 64'h2000, 64'h0, 2'b10, 0, 1'b0, 64'h0);
      chk("req_count_oob", k, 64'(reqs[k] - r0), 64'd0);
      rd(k, 64'h13, 64'h10, 64'h0202020202020202, 2'b00, 0, 1'b0, 64'h0);
      rd(k, 64'h10, 64'h10, 64'h0202020202020202, 2'b00, 5, 1'b1, 64'h8);
      rd(k, 64'h8, 64'h8, 64'h0101010101010101, 2'b00, 0, 1'b0, 64'h0);
      r0 = reqs[k];
      fork
        wr(k, 3, 0);
        rd(k, 64'h18, 64'h18, 64'h0303030303030303, 2'b00, 2, 1'b0, 64'h0);
      join
      wr(k, 0, 4);
      chk("req_count_write", k, 64'(reqs[k] - r0), 64'd1);
    end
    fork
      aw_hs(1);
      w_hs(1);
    join
    wait_b(1);
    @(posedge clk); #1;
    ar_hs(1, 64'h8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ar_ready", 1, 64'(ar_ready[1]), 64'd1);
    chk("arst_aw_ready", 1, 64'(aw_ready[1]), 64'd1);
    chk("arst_w_ready", 1, 64'(w_ready[1]), 64'd1);
    chk("arst_r_valid", 1, 64'(r_valid[1]), 64'd0);
    chk("arst_b_valid", 1, 64'(b_valid[1]), 64'd0);
    chk("arst_rom_req", 1, 64'(rom_req[1]), 64'd0);
    chk("arst_rom_addr", 1, rom_addr[1], 64'd0);
    chk("arst_r_data", 1, r_data[1], 64'd0);
    chk("arst_r_resp", 1, 64'(r_resp[1]), 64'd0);
    chk("arst_b_resp", 1, 64'(b_resp[1]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(1, 64'h10, 64'h10, 64'h0202020202020202, 2'b00, 0, 1'b0, 64'h0);
    wr(1, 0, 1);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
